wb_mem_arbiter: RTL

- Round-robin Wishbone B3 arbiter that shares the single TxRx data memory slave port between NUM_MASTERS requesters.
- Typical requesters: the Ethernet MAC DMA master and a test/host master.
- Holds the grant for a whole bus cycle (cyc) and routes ack/err/rty back to the owning master only.
- Provides a watchdog that terminates a hung access with err when the slave never responds.

---
 rtl/wb_mem_arbiter_pkg.sv | 19 +
 rtl/wb_mem_arbiter_if.sv | 47 ++++
 rtl/wb_mem_arbiter_rr_pick.sv | 28 ++
 rtl/wb_mem_arbiter.sv | 122 ++++++++++++
 4 files changed

// File: rtl/wb_mem_arbiter_pkg.sv
// Shared types and width helpers for the Wishbone memory-port arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_TOUT = 2'd2
  } arb_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Wide enough to hold TIMEOUT_CYC itself, so the counter never wraps.
  function automatic int cnt_width(input int t);
    return $clog2(t + 1);
  endfunction

endpackage

// File: rtl/wb_mem_arbiter_if.sv
// Bundle of the per-master request side and the single shared slave side.
interface wb_mem_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
);
  localparam int SEL_W = DATA_W / 8;

  logic [NUM_MASTERS-1:0]             m_cyc_i;
  logic [NUM_MASTERS-1:0]             m_stb_i;
  logic [NUM_MASTERS-1:0]             m_we_i;
  logic [NUM_MASTERS-1:0][ADDR_W-1:0] m_adr_i;
  logic [NUM_MASTERS-1:0][DATA_W-1:0] m_dat_i;
  logic [NUM_MASTERS-1:0][SEL_W-1:0]  m_sel_i;
  logic [DATA_W-1:0]                  m_dat_o;
  logic [NUM_MASTERS-1:0]             m_ack_o;
  logic [NUM_MASTERS-1:0]             m_err_o;
  logic [NUM_MASTERS-1:0]             m_rty_o;

  logic                               s_cyc_o;
  logic                               s_stb_o;
  logic                               s_we_o;
  logic [ADDR_W-1:0]                  s_adr_o;
  logic [DATA_W-1:0]                  s_dat_o;
  logic [SEL_W-1:0]                   s_sel_o;
  logic [DATA_W-1:0]                  s_dat_i;
  logic                               s_ack_i;
  logic                               s_err_i;
  logic                               s_rty_i;

  modport arb (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
    input  s_dat_i, s_ack_i, s_err_i, s_rty_i,
    output m_dat_o, m_ack_o, m_err_o, m_rty_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
    input  m_dat_o, m_ack_o, m_err_o, m_rty_o
  );

  modport slave (
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    output s_dat_i, s_ack_i, s_err_i, s_rty_i
  );
endinterface

// File: rtl/wb_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first request found after the last winner.
module wb_rr_pick
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = idx_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       last,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic [IDX_W-1:0]       idx,
  output logic                   any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      if (!any && req[(int'(last) + k) % NUM_MASTERS]) begin
        any = 1'b1;
        gnt[(int'(last) + k) % NUM_MASTERS] = 1'b1;
        idx = IDX_W'((int'(last) + k) % NUM_MASTERS);
      end
    end
  end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Round-robin Wishbone B3 arbiter sharing one memory slave port, with a
// watchdog that terminates a hung access with err.
module wb_mem_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int TIMEOUT_CYC = 16,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_n_i,
  wb_mem_arbiter_if.arb          bus,
  output logic [NUM_MASTERS-1:0] gnt_o,
  output logic                   timeout_o
);

  localparam int IDX_W = idx_width(NUM_MASTERS);
  localparam int CNT_W = cnt_width(TIMEOUT_CYC);

  arb_state_e             state_q;
  logic [NUM_MASTERS-1:0] gnt_q;
  logic [IDX_W-1:0]       gidx_q;
  logic [IDX_W-1:0]       last_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   timeout_q;

  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;
  logic                   own_cyc;
  logic                   fwd;
  logic                   s_stb;
  logic                   term;
  logic                   tmo_hit;

  wb_rr_pick #(
    .NUM_MASTERS(NUM_MASTERS),
    .IDX_W      (IDX_W)
  ) u_pick (
    .req (bus.m_cyc_i),
    .last(last_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Forwarding is combinational so the owner's cyc drop reaches the slave at once.
  assign own_cyc = bus.m_cyc_i[gidx_q];
  assign fwd     = (state_q == ST_BUSY) && own_cyc;
  assign s_stb   = fwd && bus.m_stb_i[gidx_q];
  assign term    = bus.s_ack_i || bus.s_err_i || bus.s_rty_i;
  assign tmo_hit = s_stb && !term && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  assign bus.s_cyc_o = fwd;
  assign bus.s_stb_o = s_stb;
  assign bus.s_we_o  = fwd && bus.m_we_i[gidx_q];
  assign bus.s_adr_o = bus.m_adr_i[gidx_q];
  assign bus.s_dat_o = bus.m_dat_i[gidx_q];
  assign bus.s_sel_o = bus.m_sel_i[gidx_q];

  assign bus.m_dat_o = bus.s_dat_i;
  assign bus.m_ack_o = gnt_q & {NUM_MASTERS{s_stb && bus.s_ack_i}};
  assign bus.m_err_o = gnt_q & {NUM_MASTERS{(s_stb && bus.s_err_i) || timeout_q}};
  assign bus.m_rty_o = gnt_q & {NUM_MASTERS{s_stb && bus.s_rty_i}};

  assign gnt_o     = gnt_q;
  assign timeout_o = timeout_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      gidx_q    <= '0;
      last_q    <= IDX_W'(NUM_MASTERS - 1);
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (pick_any) begin
            state_q <= ST_BUSY;
            gnt_q   <= pick_gnt;
            gidx_q  <= pick_idx;
            last_q  <= pick_idx;
          end
        end
        ST_BUSY: begin
          if (!own_cyc) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            cnt_q   <= '0;
          end else if (tmo_hit) begin
            state_q   <= ST_TOUT;
            timeout_q <= 1'b1;
            cnt_q     <= '0;
          end else if (s_stb && !term) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            cnt_q <= '0;
          end
        end
        // Slave side is dead here; wait for the owner to close its cycle.
        ST_TOUT: begin
          cnt_q <= '0;
          if (!own_cyc) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule
